// File: rtl/data_read_sample_fifo_pkg.sv
// Shared data_read definitions: default geometry of the capture FIFO and the
// status-bit positions used by the AXI-lite register map.
package data_read_sample_fifo_pkg;

    localparam int DR_DATA_WIDTH    = 32;
    localparam int DR_ADDR_WIDTH    = 4;
    localparam int DR_OVF_CNT_WIDTH = 16;

    localparam int DR_STAT_EMPTY_BIT = 0;
    localparam int DR_STAT_FULL_BIT  = 1;
    localparam int DR_STAT_OVF_BIT   = 2;

endpackage

// File: rtl/data_read_fifo_ram.sv
// Simple dual-port sample storage: one write port and one synchronous, enabled
// read port. The array itself carries no reset so it can map onto RAM.
module data_read_fifo_ram
    import data_read_sample_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DR_DATA_WIDTH,
    parameter int ADDR_WIDTH = DR_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register: holds the last popped word until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/data_read_sample_fifo.sv
// Capture FIFO in front of the data_read AXI-lite slave: registered pop port,
// registered level/flags, sticky overflow flag with saturating drop counter.
module data_read_sample_fifo
    import data_read_sample_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DR_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DR_ADDR_WIDTH,
    parameter int OVF_CNT_WIDTH = DR_OVF_CNT_WIDTH
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESET,
    input  logic                     CAP_EN,
    input  logic [DATA_WIDTH-1:0]    DIN,
    input  logic                     DIN_VALID,
    input  logic                     FLUSH,
    input  logic                     POP,
    output logic [DATA_WIDTH-1:0]    DOUT,
    output logic                     DOUT_VALID,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [ADDR_WIDTH:0]      LEVEL,
    output logic                     OVF,
    output logic [OVF_CNT_WIDTH-1:0] OVF_CNT,
    input  logic                     CLR_OVF
);

    logic [ADDR_WIDTH:0]      wr_ptr_r, rd_ptr_r, level_r;
    logic [ADDR_WIDTH:0]      wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic                     empty_r, full_r, dout_valid_r, ovf_r;
    logic                     empty_nxt_s, full_nxt_s;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_r;
    logic                     pop_ok_s, push_ok_s, drop_s, wr_en_s, rd_en_s;

    function automatic logic [OVF_CNT_WIDTH-1:0] sat_inc(input logic [OVF_CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(OVF_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    // Handshake qualification; FLUSH discards whatever was accepted this cycle.
    always_comb begin
        pop_ok_s  = POP & ~empty_r;
        push_ok_s = CAP_EN & DIN_VALID & (~full_r | pop_ok_s);
        drop_s    = CAP_EN & DIN_VALID & full_r & ~pop_ok_s;
        wr_en_s   = push_ok_s & ~FLUSH;
        rd_en_s   = pop_ok_s & ~FLUSH;
    end

    // Next pointers and flags; the extra pointer MSB separates full from empty.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (FLUSH) begin
            wr_ptr_nxt_s = {(ADDR_WIDTH+1){1'b0}};
            rd_ptr_nxt_s = {(ADDR_WIDTH+1){1'b0}};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + {{ADDR_WIDTH{1'b0}}, wr_en_s};
            rd_ptr_nxt_s = rd_ptr_r + {{ADDR_WIDTH{1'b0}}, rd_en_s};
        end
        empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        full_nxt_s  = (wr_ptr_nxt_s[ADDR_WIDTH] != rd_ptr_nxt_s[ADDR_WIDTH]) &&
                      (wr_ptr_nxt_s[ADDR_WIDTH-1:0] == rd_ptr_nxt_s[ADDR_WIDTH-1:0]);
    end

    // Pointer, level, flag and pop-strobe registers.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_ptr_r     <= {(ADDR_WIDTH+1){1'b0}};
            rd_ptr_r     <= {(ADDR_WIDTH+1){1'b0}};
            level_r      <= {(ADDR_WIDTH+1){1'b0}};
            empty_r      <= 1'b1;
            full_r       <= 1'b0;
            dout_valid_r <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            level_r      <= wr_ptr_nxt_s - rd_ptr_nxt_s;
            empty_r      <= empty_nxt_s;
            full_r       <= full_nxt_s;
            dout_valid_r <= rd_en_s;
        end
    end

    // Overflow tracking; a drop in the same cycle as CLR_OVF restarts the count at one.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ovf_r     <= 1'b0;
            ovf_cnt_r <= {OVF_CNT_WIDTH{1'b0}};
        end else if (drop_s) begin
            ovf_r     <= 1'b1;
            ovf_cnt_r <= CLR_OVF ? {{(OVF_CNT_WIDTH-1){1'b0}}, 1'b1} : sat_inc(ovf_cnt_r);
        end else if (CLR_OVF) begin
            ovf_r     <= 1'b0;
            ovf_cnt_r <= {OVF_CNT_WIDTH{1'b0}};
        end else begin
            ovf_r     <= ovf_r;
            ovf_cnt_r <= ovf_cnt_r;
        end
    end

    data_read_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r[ADDR_WIDTH-1:0]),
        .wr_data (DIN),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_r[ADDR_WIDTH-1:0]),
        .rd_data (DOUT)
    );

    assign DOUT_VALID = dout_valid_r;
    assign EMPTY      = empty_r;
    assign FULL       = full_r;
    assign LEVEL      = level_r;
    assign OVF        = ovf_r;
    assign OVF_CNT    = ovf_cnt_r;

endmodule

// File: tb/tb_data_read_sample_fifo.sv
// Self-checking bench for data_read_sample_fifo: directed scenarios plus random
// traffic, all compared every cycle against a queue-based reference model.
module tb_data_read_sample_fifo;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int CW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cap_en = 1'b0, din_valid = 1'b0, flush = 1'b0, pop = 1'b0, clr_ovf = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          dout_valid, empty, full, ovf;
    logic [AW:0]   level;
    logic [CW-1:0] ovf_cnt;

    data_read_sample_fifo dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .CAP_EN       (cap_en),
        .DIN          (din),
        .DIN_VALID    (din_valid),
        .FLUSH        (flush),
        .POP          (pop),
        .DOUT         (dout),
        .DOUT_VALID   (dout_valid),
        .EMPTY        (empty),
        .FULL         (full),
        .LEVEL        (level),
        .OVF          (ovf),
        .OVF_CNT      (ovf_cnt),
        .CLR_OVF      (clr_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_dv = 1'b0, m_ovf = 1'b0;
    int            m_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        bit is_full, pop_ok, push_ok, drop;
        if (rst) begin
            model_reset();
        end else begin
            is_full = (m_q.size() == DEPTH);
            pop_ok  = pop && (m_q.size() > 0);
            push_ok = cap_en && din_valid && (!is_full || pop_ok);
            drop    = cap_en && din_valid && is_full && !pop_ok;
            if (flush) begin
                m_q.delete();
                m_dv = 1'b0;
            end else begin
                m_dv = pop_ok;
                if (pop_ok) m_dout = m_q.pop_front();
                if (push_ok) m_q.push_back(din);
            end
            if (drop) begin
                m_ovf = 1'b1;
                m_cnt = clr_ovf ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
            end else if (clr_ovf) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_val("dout",  dout, m_dout);
        check_val("dv",    32'(dout_valid), 32'(m_dv));
        check_val("level", 32'(level), 32'(m_q.size()));
        check_val("empty", 32'(empty), 32'(m_q.size() == 0));
        check_val("full",  32'(full), 32'(m_q.size() == DEPTH));
        check_val("ovf",   32'(ovf), 32'(m_ovf));
        check_val("ovfcnt", 32'(ovf_cnt), 32'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        din = d; din_valid = 1'b1; pop = 1'b0;
        step();
        din_valid = 1'b0;
    endtask

    task automatic pop_word();
        pop = 1'b1; din_valid = 1'b0;
        step();
        pop = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        check_val("rst_empty", 32'(empty), 32'd1);
        rst = 1'b0;
        cap_en = 1'b1;

        // Three words in, three out
        push_word(32'h11111111);
        push_word(32'h22222222);
        push_word(32'h33333333);
        check_val("t1_level", 32'(level), 32'd3);
        pop_word();
        check_val("t1_d0", dout, 32'h11111111);
        check_val("t1_v0", 32'(dout_valid), 32'd1);
        pop_word();
        pop_word();
        check_val("t1_d2", dout, 32'h33333333);
        step();
        check_val("t1_vlow", 32'(dout_valid), 32'd0);
        check_val("t1_empty", 32'(empty), 32'd1);

        // Fill, overflow by one, drain
        for (int i = 0; i < DEPTH; i++) push_word(DW'(i));
        push_word(32'h0000DEAD);
        check_val("t2_full", 32'(full), 32'd1);
        check_val("t2_ovf", 32'(ovf), 32'd1);
        check_val("t2_cnt", 32'(ovf_cnt), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_word();
        check_val("t2_last", dout, 32'd15);

        // Push while full with a simultaneous pop
        for (int i = 0; i < DEPTH; i++) push_word(DW'(i + 100));
        din = 32'h0000BEEF; din_valid = 1'b1; pop = 1'b1;
        step();
        din_valid = 1'b0; pop = 1'b0;
        check_val("t3_level", 32'(level), 32'd16);
        check_val("t3_cnt", 32'(ovf_cnt), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_word();
        check_val("t3_last", dout, 32'h0000BEEF);

        // Interleaved traffic across the pointer wrap
        push_word(32'hA0000000);
        for (int i = 0; i < 40; i++) begin
            din = 32'hA0000001 + DW'(i);
            din_valid = 1'b1;
            pop = (m_q.size() >= 1 + (i % 3));
            step();
        end
        din_valid = 1'b0;
        while (m_q.size() > 0) pop_word();
        pop_word();
        check_val("t4_empty_pop", 32'(dout_valid), 32'd0);

        // Counter saturation, then clear-with-drop and plain clear
        for (int i = 0; i < DEPTH; i++) push_word($urandom);
        din_valid = 1'b1;
        repeat (70000) step();
        check_val("t5_sat", 32'(ovf_cnt), 32'h0000FFFF);
        clr_ovf = 1'b1;
        step();
        check_val("t5_clrdrop", 32'(ovf_cnt), 32'd1);
        check_val("t5_clrdrop_ovf", 32'(ovf), 32'd1);
        din_valid = 1'b0;
        step();
        clr_ovf = 1'b0;
        check_val("t5_clr", 32'(ovf_cnt), 32'd0);

        // Flush at level 5 with a concurrent pop and push
        push_word(32'h5A5A5A5A);
        for (int i = 0; i < DEPTH - 5; i++) pop_word();
        check_val("t6_lvl5", 32'(level), 32'd5);
        flush = 1'b1; pop = 1'b1; din = 32'h12345678; din_valid = 1'b1;
        step();
        flush = 1'b0; pop = 1'b0; din_valid = 1'b0;
        check_val("t6_level", 32'(level), 32'd0);
        check_val("t6_dv", 32'(dout_valid), 32'd0);
        check_val("t6_ovf", 32'(ovf), 32'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cap_en    = ($urandom_range(3) != 0);
            din_valid = $urandom_range(1);
            din       = $urandom;
            pop       = $urandom_range(1);
            flush     = ($urandom_range(31) == 0);
            clr_ovf   = ($urandom_range(15) == 0);
            step();
        end
        flush = 1'b0; clr_ovf = 1'b0; pop = 1'b0;
        cap_en = 1'b1; din_valid = 1'b1;
        repeat (20) step();

        // Asynchronous reset in mid-stream
        #2 rst = 1'b1;
        #1;
        check_val("rst_dout", dout, 32'd0);
        check_val("rst_dv", 32'(dout_valid), 32'd0);
        check_val("rst_empty2", 32'(empty), 32'd1);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        check_val("rst_cnt", 32'(ovf_cnt), 32'd0);
        din_valid = 1'b0;
        step();
        rst = 1'b0;
        push_word(32'hCAFEF00D);
        pop_word();
        check_val("post_rst", dout, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_read_sample_fifo.md
Name: data_read_sample_fifo

Overview:
Capture-side buffer that sits directly upstream of the data_read AXI-lite slave. It accepts words from the external acquisition source and stores them in a FIFO. It presents a registered pop interface, which the AXI read channel drains one word per read of the data register. It also exposes fill level, full/empty flags and a sticky overflow indication with a saturating drop counter, which the AXI side maps onto status registers.

Parameters:
DATA_WIDTH, 32, width of sample words and DOUT.
ADDR_WIDTH, 4, log2 of FIFO depth (default depth 16).
OVF_CNT_WIDTH, 16, width of the dropped-word counter.

Ports:
S_AXI_ACLK  in  1  single clock shared with the AXI slave.
S_AXI_ARESET  in  1  asynchronous, active-high reset.
CAP_EN  in  1  capture enable; DIN_VALID is ignored while low.
DIN  in  DATA_WIDTH  sample word from the source.
DIN_VALID  in  1  DIN qualifier; one word per cycle when high.
FLUSH  in  1  synchronous flush request (one-cycle pulse from a control register write).
POP  in  1  read request from the AXI read stage.
DOUT  out  DATA_WIDTH  popped word (registered).
DOUT_VALID  out  1  one-cycle pulse marking DOUT as new.
EMPTY  out  1  FIFO holds 0 words.
FULL  out  1  FIFO holds 2^ADDR_WIDTH words.
LEVEL  out  ADDR_WIDTH+1  current word count, 0..2^ADDR_WIDTH.
OVF  out  1  sticky flag: at least one word dropped.
OVF_CNT  out  OVF_CNT_WIDTH  dropped-word count, saturating.
CLR_OVF  in  1  clears OVF and OVF_CNT.

Behaviour:
- Reset (async assert, release sync to S_AXI_ACLK): pointers 0; DOUT=0, DOUT_VALID=0, EMPTY=1, FULL=0, LEVEL=0, OVF=0, OVF_CNT=0.
- pop_ok = POP & ~EMPTY.
- push_ok = CAP_EN & DIN_VALID & (~FULL | pop_ok).
  - Push on a full FIFO is legal only when a pop is accepted in the same cycle.
- drop = CAP_EN & DIN_VALID & FULL & ~pop_ok.
- Push: word written at wr_ptr; wr_ptr increments modulo depth. EMPTY deasserts the next cycle.
- Pop: DOUT <= mem[rd_ptr] and DOUT_VALID=1 in the cycle after POP; rd_ptr increments modulo depth.
  - DOUT holds its value when no pop occurs.
  - DOUT_VALID is 0 in every cycle not following an accepted pop.
- POP while EMPTY is ignored: no pointer change, DOUT unchanged, DOUT_VALID stays 0.
- Simultaneous push and pop: LEVEL unchanged.
  - If EMPTY at that time, only the push is accepted and LEVEL becomes 1.
- Latency: word pushed in cycle N is visible (EMPTY=0, LEVEL=1) in N+1. POP in N+1 yields DOUT_VALID in N+2.
- LEVEL, EMPTY and FULL are registered and consistent with each other every cycle.
  - Full/empty are distinguished with an extra pointer MSB; wrap-around of ADDR_WIDTH bits must not alias.
- FLUSH has highest priority. Next cycle: pointers 0, LEVEL=0, EMPTY=1, FULL=0, DOUT_VALID=0.
  - DOUT keeps its last value.
  - A push or pop in the FLUSH cycle is discarded.
  - OVF and OVF_CNT are not affected by FLUSH.
- Overflow: on drop, OVF<=1 and OVF_CNT increments, saturating at all-ones.
  - CLR_OVF clears both next cycle.
  - If CLR_OVF and drop occur together, the drop wins: OVF=1, OVF_CNT=1.
- CAP_EN low: no pushes and no drops; pops continue normally.
- Reset mid-operation: all state returns to reset values immediately; the stored data is discarded.

Decomposition:
- Shared data_read package/header holds:
  - DATA_WIDTH default;
  - ADDR_WIDTH default;
  - OVF_CNT_WIDTH default;
  - status-bit positions (EMPTY=0, FULL=1, OVF=2) used by the AXI register map.
- One sub-module: data_read_fifo_ram. It is a simple dual-port storage array (write port, synchronous read port) with no reset on the array, so it can infer distributed/block RAM.
- Pointer, level and overflow logic stays in the top module.

Test Plan:
- Reset, then push 0x11111111..0x33333333 (3 words) with CAP_EN=1 -> LEVEL=3, EMPTY=0. Three POPs -> DOUT 0x11111111, 0x22222222, 0x33333333 with DOUT_VALID one cycle after each POP, then EMPTY=1.
- Push 16 words (0..15), then a 17th word 0xDEAD -> FULL=1, OVF=1, OVF_CNT=1. Pop all 16 -> data 0..15 in order and 0xDEAD absent.
- With FULL, drive POP and push 0xBEEF in the same cycle -> push accepted, LEVEL stays 16, OVF unchanged. Draining gives 0xBEEF last.
- Pointer wrap: perform 40 interleaved push/pop cycles at LEVEL 1..3 -> data order preserved across the pointer wrap. POP on empty -> no DOUT_VALID.
- Hold FULL and drive DIN_VALID for 70000 cycles -> OVF_CNT saturates at 0xFFFF. CLR_OVF together with a drop -> OVF=1, OVF_CNT=1.
- FLUSH with LEVEL=5 and POP in the same cycle -> next cycle LEVEL=0, EMPTY=1, DOUT_VALID=0, OVF retained. Assert S_AXI_ARESET mid-stream -> all outputs return to reset values asynchronously.
